// File: rtl/booth_pkg.sv
// booth_pkg: shared constants and types for the sequential Booth multiplier.
//   BOOTH_WIDTH : default operand width
//   state_t     : controller states (IDLE, RUN, DONE)
//   CNT_W       : step-counter width for the default operand width
package booth_pkg;

  localparam int BOOTH_WIDTH = 8;

  // The counter has to hold the value WIDTH itself, hence WIDTH+1.
  localparam int CNT_W = $clog2(BOOTH_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_step.sv
// booth_step: one combinational radix-2 Booth iteration.
//   acc, q, q_1, m          : current partial remainder, multiplier, guard bit
//                             and sign-extended multiplicand
//   acc_next, q_next,
//   q_1_next                : values after the add/sub and arithmetic right shift
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_1_next
);

  logic [WIDTH:0] sum;

  // Pair {q[0], q_1}: 01 adds M, 10 subtracts M, 00/11 leave A unchanged.
  always_comb begin
    sum = acc;
    case ({q[0], q_1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
  end

  // Arithmetic shift of {A,Q,q_1}: A's MSB is replicated, A's LSB enters Q.
  assign acc_next = {sum[WIDTH], sum[WIDTH:1]};
  assign q_next   = {sum[0], q[WIDTH-1:1]};
  assign q_1_next = q[0];

endmodule

// File: rtl/booth_multiplier_seq.sv
// booth_multiplier_seq: sequential radix-2 Booth multiplier, one step per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request; accepted on a clk edge while the controller is IDLE
//   a, b       : signed multiplicand / multiplier, captured on acceptance
//   busy       : high from the cycle after acceptance through the done cycle
//   done       : one-cycle pulse, c holds a new product
//   c          : signed 2*WIDTH-bit product, held until the next completion
//   fsm_state  : current controller state (debug observation)
//
// Handshake: start is a level request sampled on each rising edge while the
// controller is IDLE; once taken, start/a/b are ignored until done. Because
// the done cycle already sits in IDLE, a start held high is taken on the edge
// right after done, giving one product every WIDTH+2 cycles.
module booth_multiplier_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] c,
  output state_t             fsm_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  state_t           state;
  logic [WIDTH:0]   m;      // multiplicand, one extra bit so -M never overflows
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic             q_1;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   acc_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             q_1_nxt;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .q        (q),
    .q_1      (q_1),
    .m        (m),
    .acc_next (acc_nxt),
    .q_next   (q_nxt),
    .q_1_next (q_1_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      m     <= '0;
      acc   <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      count <= '0;
      c     <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m     <= {a[WIDTH-1], a};
            acc   <= '0;
            q     <= b;
            q_1   <= 1'b0;
            count <= CNT_INIT;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          q     <= q_nxt;
          q_1   <= q_1_nxt;
          count <= count - CNT_LAST;
          // All WIDTH steps always run, zero operands included.
          if (count == CNT_LAST) state <= DONE;
        end
        DONE: begin
          c     <= {acc[WIDTH-1:0], q};
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The done cycle is already IDLE, so busy folds done in to stay high through it.
  assign busy      = (state != IDLE) || done;
  assign fsm_state = state;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
module tb_booth_multiplier_seq;
  import booth_pkg::*;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] c;
  state_t         fsm_state;

  int checks;
  int errors;
  int done_cnt;
  logic [2*W-1:0] exp_q[$];

  booth_multiplier_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .c         (c),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // ---------------- reference model ----------------
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    int px;
    int py;
    px = int'($signed(x));
    py = int'($signed(y));
    return (2*W)'(px * py);
  endfunction

  // ---------------- driver tasks ----------------
  // Present a request at a negedge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges until done is seen; lat equals the edge index after the start edge.
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || c !== '0 || fsm_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b c=%h state=%0d, want 0 0 0000 IDLE",
               busy, done, c, fsm_state);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int lat;
    int d0;
    logic [2*W-1:0] exp;
    exp = ref_mul(8'd15, 8'd3);
    d0 = done_cnt;
    launch(8'd15, 8'd3);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: busy=%b want 1", busy);
    end
    wait_done(lat);
    checks++;
    if (lat != W + 1) begin
      errors++;
      $display("FAIL basic_latency: got %0d want %0d", lat, W + 1);
    end
    checks++;
    if (c !== exp || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_product: c=%0d busy=%b want %0d busy=1", $signed(c), busy, $signed(exp));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || c !== exp || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL basic_after: done=%b busy=%b c=%0d pulses=%0d want 0 0 %0d 1",
               done, busy, $signed(c), done_cnt - d0, $signed(exp));
    end
  endtask

  task automatic run_table(input string tag, input logic [W-1:0] xs[4], input logic [W-1:0] ys[4]);
    int lat;
    int d0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ref_mul(xs[i], ys[i]));
      d0 = done_cnt;
      launch(xs[i], ys[i]);
      wait_done(lat);
      @(negedge clk);
      checks++;
      if (c !== exp_q[0] || lat != W + 1 || done_cnt - d0 != 1) begin
        errors++;
        $display("FAIL %s_%0d: c=%0d lat=%0d pulses=%0d want c=%0d lat=%0d pulses=1",
                 tag, i, $signed(c), lat, done_cnt - d0, $signed(exp_q[0]), W + 1);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] xs[4] = '{8'd12, -8'sd8, -8'sd7, 8'd0};
    logic [W-1:0] ys[4] = '{-8'sd5, 8'd6, -8'sd9, 8'd25};
    run_table("b2b", xs, ys);
  endtask

  task automatic test_extremes();
    logic [W-1:0] xs[4] = '{8'h7f, 8'h80, 8'h80, 8'h7f};
    logic [W-1:0] ys[4] = '{8'h80, 8'h80, 8'h7f, 8'h7f};
    run_table("ext", xs, ys);
  endtask

  task automatic test_ignore_start();
    int lat;
    int d0;
    logic [2*W-1:0] exp;
    exp = ref_mul(8'd15, 8'd3);
    d0 = done_cnt;
    launch(8'd15, 8'd3);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (lat == 4) begin
        start = 1'b1;
        a     = 8'hff;
        b     = 8'hff;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    checks++;
    if (c !== exp || lat != W + 1) begin
      errors++;
      $display("FAIL ignore_start_product: c=%0d lat=%0d want %0d lat=%0d", $signed(c), lat, $signed(exp), W + 1);
    end
    repeat (15) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_pulses: pulses=%0d busy=%b want 1 0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    int d0;
    launch(8'd12, -8'sd5);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || c !== '0 || fsm_state !== IDLE) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b c=%h state=%0d want 0 0 0000 IDLE",
               busy, done, c, fsm_state);
    end
    d0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_abandon: pulses=%0d busy=%b want 0 0", done_cnt - d0, busy);
    end
    launch(8'd2, 8'd3);
    wait_done(lat);
    checks++;
    if (c !== ref_mul(8'd2, 8'd3) || lat != W + 1) begin
      errors++;
      $display("FAIL post_reset_op: c=%0d lat=%0d want 6 lat=%0d", $signed(c), lat, W + 1);
    end
  endtask

  task automatic test_random_sweep();
    int gap;
    logic [W-1:0] x;
    logic [W-1:0] y;
    @(negedge clk);
    x = W'($urandom_range(0, 255));
    y = W'($urandom_range(0, 255));
    start = 1'b1;
    a = x;
    b = y;
    exp_q.push_back(ref_mul(x, y));
    for (int i = 0; i < 1000; i++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (done !== 1'b1 && gap < 40);
      checks++;
      if (gap != W + 2 || c !== exp_q[0]) begin
        errors++;
        $display("FAIL sweep_%0d: c=%0d gap=%0d want c=%0d gap=%0d", i, $signed(c), gap, $signed(exp_q[0]), W + 2);
      end
      void'(exp_q.pop_front());
      if (i < 999) begin
        case ($urandom_range(0, 9))
          0:       x = 8'h80;
          1:       x = 8'h7f;
          2:       x = 8'h00;
          default: x = W'($urandom_range(0, 255));
        endcase
        case ($urandom_range(0, 9))
          0:       y = 8'h80;
          1:       y = 8'hff;
          2:       y = 8'h00;
          default: y = W'($urandom_range(0, 255));
        endcase
        a = x;
        b = y;
        exp_q.push_back(ref_mul(x, y));
      end else begin
        start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL sweep_end: busy=%b pending=%0d want 0 0", busy, exp_q.size());
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_extremes();
    test_ignore_start();
    test_reset_mid_op();
    test_random_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
